// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection from decode
// redirects, and the IF/ID pipeline register feeding decode.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  PCSrc,
    input  logic        BranchHazard,
    input  logic        JumpHazard,
    input  logic        DataHazard,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_PC_plus_4,
    output logic [31:0] IF_ID_PC_Interrupt
);

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus_4;
        logic [31:0] pc_interrupt;
    } if_id_t;

    logic [31:0] pc_q;
    if_id_t      if_id_q;
    logic [31:0] pc_plus_4;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;
    logic        redirect;

    // Sequential increment never touches the supervisor bit.
    assign pc_plus_4 = {pc_q[31], pc_q[30:0] + 31'd4};

    always_comb begin
        next_pc_raw = pc_plus_4;
        case (PCSrc)
            3'b001:  next_pc_raw = BranchHazard ? branch_target : pc_plus_4;
            3'b010:  next_pc_raw = jump_target;
            3'b011:  next_pc_raw = jr_target;
            3'b100:  next_pc_raw = ILLOP_PC;
            3'b101:  next_pc_raw = XADR_PC;
            default: next_pc_raw = pc_plus_4;
        endcase
    end

    assign next_pc  = {next_pc_raw[31:2], 2'b00};
    assign redirect = BranchHazard | JumpHazard | (PCSrc == 3'b100) | (PCSrc == 3'b101);

    // Stall beats redirect; decode re-presents the redirect once the stall clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q                 <= RESET_PC;
            if_id_q.instruction  <= NOP_INST;
            if_id_q.pc_plus_4    <= RESET_PC;
            if_id_q.pc_interrupt <= RESET_PC;
        end else if (DataHazard) begin
            pc_q    <= pc_q;
            if_id_q <= if_id_q;
        end else if (redirect) begin
            pc_q                 <= next_pc;
            if_id_q.instruction  <= NOP_INST;
            if_id_q.pc_plus_4    <= next_pc;
            if_id_q.pc_interrupt <= next_pc;
        end else begin
            pc_q                 <= next_pc;
            if_id_q.instruction  <= imem_rdata;
            if_id_q.pc_plus_4    <= pc_plus_4;
            if_id_q.pc_interrupt <= pc_q;
        end
    end

    assign imem_addr          = pc_q;
    assign PC                 = pc_q;
    assign IF_ID_instruction  = if_id_q.instruction;
    assign IF_ID_PC_plus_4    = if_id_q.pc_plus_4;
    assign IF_ID_PC_Interrupt = if_id_q.pc_interrupt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; imem returns its own address as the instruction.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  PCSrc;
    logic        BranchHazard, JumpHazard, DataHazard;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] PC, IF_ID_instruction, IF_ID_PC_plus_4, IF_ID_PC_Interrupt;

    int passed = 0;
    int total  = 0;

    if_stage dut (
        .clk                (clk),
        .rst                (rst),
        .PCSrc              (PCSrc),
        .BranchHazard       (BranchHazard),
        .JumpHazard         (JumpHazard),
        .DataHazard         (DataHazard),
        .branch_target      (branch_target),
        .jump_target        (jump_target),
        .jr_target          (jr_target),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .PC                 (PC),
        .IF_ID_instruction  (IF_ID_instruction),
        .IF_ID_PC_plus_4    (IF_ID_PC_plus_4),
        .IF_ID_PC_Interrupt (IF_ID_PC_Interrupt)
    );

    always #5 clk = ~clk;
    assign imem_rdata = imem_addr;

    // observed state packed as {PC, instruction, pc_plus_4, pc_interrupt}
    logic [127:0] obs;
    assign obs = {PC, IF_ID_instruction, IF_ID_PC_plus_4, IF_ID_PC_Interrupt};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PCSrc = 3'b000; BranchHazard = 1'b0; JumpHazard = 1'b0; DataHazard = 1'b0;
        branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0;
    endtask

    task automatic jump_to(input logic [31:0] t);
        PCSrc = 3'b010; JumpHazard = 1'b1; jump_target = t;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1;
        step(); step(); step();
        total++; if (obs !== {32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000})
            $display("FAIL reset_state got %h exp %h", obs, {32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000}); else passed++;
        total++; if (imem_addr !== 32'h8000_0000)
            $display("FAIL reset_imem_addr got %h exp %h", imem_addr, 32'h8000_0000); else passed++;
    endtask

    task automatic test_free_run();
        rst = 1'b0;
        step();
        total++; if (obs !== {32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 32'h8000_0000})
            $display("FAIL run1 got %h exp %h", obs, {32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 32'h8000_0000}); else passed++;
        step();
        total++; if (obs !== {32'h8000_0008, 32'h8000_0004, 32'h8000_0008, 32'h8000_0004})
            $display("FAIL run2 got %h exp %h", obs, {32'h8000_0008, 32'h8000_0004, 32'h8000_0008, 32'h8000_0004}); else passed++;
        total++; if (imem_addr !== 32'h8000_0008)
            $display("FAIL run_imem_addr got %h exp %h", imem_addr, 32'h8000_0008); else passed++;
    endtask

    task automatic test_branch();
        jump_to(32'h0000_0040);
        total++; if (obs !== {32'h40, 32'h0, 32'h40, 32'h40})
            $display("FAIL jump_setup got %h exp %h", obs, {32'h40, 32'h0, 32'h40, 32'h40}); else passed++;
        PCSrc = 3'b001; BranchHazard = 1'b1; branch_target = 32'h0000_0100;
        step(); idle();
        total++; if (obs !== {32'h100, 32'h0, 32'h100, 32'h100})
            $display("FAIL branch_taken got %h exp %h", obs, {32'h100, 32'h0, 32'h100, 32'h100}); else passed++;
        jump_to(32'h0000_0040);
        PCSrc = 3'b001; BranchHazard = 1'b0; branch_target = 32'h0000_0100;
        step(); idle();
        total++; if (obs !== {32'h44, 32'h40, 32'h44, 32'h40})
            $display("FAIL branch_not_taken got %h exp %h", obs, {32'h44, 32'h40, 32'h44, 32'h40}); else passed++;
    endtask

    task automatic test_stall();
        DataHazard = 1'b1; JumpHazard = 1'b1; PCSrc = 3'b010; jump_target = 32'h0000_0200;
        step();
        total++; if (obs !== {32'h44, 32'h40, 32'h44, 32'h40})
            $display("FAIL stall_hold1 got %h exp %h", obs, {32'h44, 32'h40, 32'h44, 32'h40}); else passed++;
        step();
        total++; if (obs !== {32'h44, 32'h40, 32'h44, 32'h40})
            $display("FAIL stall_hold2 got %h exp %h", obs, {32'h44, 32'h40, 32'h44, 32'h40}); else passed++;
        DataHazard = 1'b0;
        step(); idle();
        total++; if (obs !== {32'h200, 32'h0, 32'h200, 32'h200})
            $display("FAIL stall_release got %h exp %h", obs, {32'h200, 32'h0, 32'h200, 32'h200}); else passed++;
        step();
        total++; if (obs !== {32'h204, 32'h200, 32'h204, 32'h200})
            $display("FAIL target_in_ifid got %h exp %h", obs, {32'h204, 32'h200, 32'h204, 32'h200}); else passed++;
    endtask

    task automatic test_interrupt();
        PCSrc = 3'b100;
        step();
        total++; if (obs !== {32'h8000_0004, 32'h0, 32'h8000_0004, 32'h8000_0004})
            $display("FAIL interrupt got %h exp %h", obs, {32'h8000_0004, 32'h0, 32'h8000_0004, 32'h8000_0004}); else passed++;
        PCSrc = 3'b101;
        step();
        total++; if (obs !== {32'h8000_0008, 32'h0, 32'h8000_0008, 32'h8000_0008})
            $display("FAIL exception got %h exp %h", obs, {32'h8000_0008, 32'h0, 32'h8000_0008, 32'h8000_0008}); else passed++;
        PCSrc = 3'b111;
        step(); idle();
        total++; if (obs !== {32'h8000_000C, 32'h8000_0008, 32'h8000_000C, 32'h8000_0008})
            $display("FAIL pcsrc_111 got %h exp %h", obs, {32'h8000_000C, 32'h8000_0008, 32'h8000_000C, 32'h8000_0008}); else passed++;
    endtask

    task automatic test_wrap_mode();
        jump_to(32'h7FFF_FFFC);
        step();
        total++; if (obs !== {32'h0, 32'h7FFF_FFFC, 32'h0, 32'h7FFF_FFFC})
            $display("FAIL wrap_user got %h exp %h", obs, {32'h0, 32'h7FFF_FFFC, 32'h0, 32'h7FFF_FFFC}); else passed++;
        jump_to(32'hFFFF_FFFC);
        step();
        total++; if (obs !== {32'h8000_0000, 32'hFFFF_FFFC, 32'h8000_0000, 32'hFFFF_FFFC})
            $display("FAIL wrap_super got %h exp %h", obs, {32'h8000_0000, 32'hFFFF_FFFC, 32'h8000_0000, 32'hFFFF_FFFC}); else passed++;
        PCSrc = 3'b011; JumpHazard = 1'b1; jr_target = 32'h0040_0003;
        step(); idle();
        total++; if (obs !== {32'h0040_0000, 32'h0, 32'h0040_0000, 32'h0040_0000})
            $display("FAIL jr_user_align got %h exp %h", obs, {32'h0040_0000, 32'h0, 32'h0040_0000, 32'h0040_0000}); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        step();
        DataHazard = 1'b1; JumpHazard = 1'b1; PCSrc = 3'b010; jump_target = 32'h0000_0300;
        step();
        total++; if (obs !== {32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'h0040_0000})
            $display("FAIL pre_reset_stall got %h exp %h", obs, {32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'h0040_0000}); else passed++;
        rst = 1'b1;
        step();
        total++; if (obs !== {32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000})
            $display("FAIL reset_mid_stall got %h exp %h", obs, {32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000}); else passed++;
        DataHazard = 1'b0;
        step();
        total++; if (obs !== {32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000})
            $display("FAIL reset_mid_flush got %h exp %h", obs, {32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000}); else passed++;
        rst = 1'b0; idle();
        step();
        total++; if (obs !== {32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 32'h8000_0000})
            $display("FAIL post_reset_run got %h exp %h", obs, {32'h8000_0004, 32'h8000_0000, 32'h8000_0004, 32'h8000_0000}); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_free_run();
        test_branch();
        test_stall();
        test_interrupt();
        test_wrap_mode();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
